// File: rtl/alu_status_stage_if.sv
// Operand/result bundle between the controller/shifter and alu_status_stage.
// master drives operands and load strobes; slave returns result and flags.
interface alu_status_stage_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] ain;
  logic [WIDTH-1:0] bin;
  logic [1:0]       alu_op;
  logic             loadc;
  logic             loads;
  logic [WIDTH-1:0] c;
  logic             z;
  logic             n;
  logic             v;
  logic             c_valid;

  modport master (
    output ain, bin, alu_op, loadc, loads,
    input  c, z, n, v, c_valid
  );

  modport slave (
    input  ain, bin, alu_op, loadc, loads,
    output c, z, n, v, c_valid
  );
endinterface

// File: rtl/alu_status_stage.sv
// Execute stage after the barrel shifter: ADD/SUB/AND/NOT-B into C, Z/N/V status.
// Define ALU_OVF_EN to build the overflow flag; otherwise v is tied to 0.
module alu_status_stage #(
  parameter int WIDTH = 16
) (
  input logic               clk,
  input logic               rst_n,
  alu_status_stage_if.slave bus
);

  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] c_q, c_d;
  logic             z_q, z_d;
  logic             n_q, n_d;
  logic             cv_q, cv_d;

  always_comb begin
    res = '0;
    unique case (bus.alu_op)
      2'b00: res = bus.ain + bus.bin;
      2'b01: res = bus.ain - bus.bin;
      2'b10: res = bus.ain & bus.bin;
      2'b11: res = ~bus.bin;
    endcase
  end

  always_comb begin
    c_d  = c_q;
    z_d  = z_q;
    n_d  = n_q;
    cv_d = bus.loadc;
    if (bus.loadc) c_d = res;
    if (bus.loads) begin
      z_d = (res == '0);
      n_d = res[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_q  <= '0;
      z_q  <= 1'b0;
      n_q  <= 1'b0;
      cv_q <= 1'b0;
    end else begin
      c_q  <= c_d;
      z_q  <= z_d;
      n_q  <= n_d;
      cv_q <= cv_d;
    end
  end

`ifdef ALU_OVF_EN
  logic sa, sb, sr;
  logic ovf;
  logic v_q, v_d;

  assign sa = bus.ain[WIDTH-1];
  assign sb = bus.bin[WIDTH-1];
  assign sr = res[WIDTH-1];

  // Signed overflow only exists for the arithmetic ops
  always_comb begin
    ovf = 1'b0;
    unique case (bus.alu_op)
      2'b00: ovf = (sa == sb) && (sr != sa);
      2'b01: ovf = (sa != sb) && (sr != sa);
      2'b10: ovf = 1'b0;
      2'b11: ovf = 1'b0;
    endcase
  end

  always_comb begin
    v_d = v_q;
    if (bus.loads) v_d = ovf;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) v_q <= 1'b0;
    else        v_q <= v_d;
  end

  assign bus.v = v_q;
`else
  assign bus.v = 1'b0;
`endif

  assign bus.c       = c_q;
  assign bus.z       = z_q;
  assign bus.n       = n_q;
  assign bus.c_valid = cv_q;

endmodule

// File: tb/tb_alu_status_stage.sv
// Self-checking bench for alu_status_stage: directed cases plus
// randomized traffic against an integer-arithmetic reference model.
module tb_alu_status_stage;

`ifdef ALU_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  logic [15:0] ec;
  logic        ez, en, ev, ecv;

  alu_status_stage_if #(.WIDTH(16)) bus ();

  alu_status_stage #(.WIDTH(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] obs();
    return {bus.c, bus.z, bus.n, bus.v, bus.c_valid};
  endfunction

  function automatic void ref_alu(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [1:0]  op,
    output logic [15:0] r,
    output logic        fz,
    output logic        fn,
    output logic        fv
  );
    int sa, sb, t;
    sa = int'($signed(a));
    sb = int'($signed(b));
    t = 0;
    fv = 1'b0;
    case (op)
      2'd0: t = sa + sb;
      2'd1: t = sa - sb;
      2'd2: t = int'(a & b);
      default: t = int'(~b);
    endcase
    r = t[15:0];
    if (op < 2'd2)
      fv = OVF && (t > 32767 || t < -32768);
    fz = (r == 16'h0000);
    fn = r[15];
  endfunction

  task automatic tick();
    logic [15:0] r;
    logic        fz, fn, fv;
    @(posedge clk);
    ref_alu(bus.ain, bus.bin, bus.alu_op, r, fz, fn, fv);
    if (!rst_n) begin
      ec = 16'h0; ez = 0; en = 0; ev = 0; ecv = 0;
    end else begin
      if (bus.loadc) ec = r;
      if (bus.loads) begin
        ez = fz; en = fn; ev = fv;
      end
      ecv = bus.loadc;
    end
    #1;
  endtask

  task automatic drive(
    input logic [1:0]  op,
    input logic [15:0] a,
    input logic [15:0] b,
    input logic        lc,
    input logic        ls
  );
    bus.alu_op = op;
    bus.ain    = a;
    bus.bin    = b;
    bus.loadc  = lc;
    bus.loads  = ls;
  endtask

  task automatic test_reset();
    logic [19:0] exp;
    rst_n = 1'b0;
    drive(2'd0, 16'h1234, 16'h4321, 1'b1, 1'b1);
    tick();
    tick();
    exp = {16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
    total++;
    if (obs() !== exp) begin
      bad++;
      $display("FAIL reset: got %h want %h", obs(), exp);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    logic [19:0] exp;
    drive(2'd0, 16'h0005, 16'h000A, 1'b1, 1'b1);
    tick();
    exp = {16'h000F, 1'b0, 1'b0, 1'b0, 1'b1};
    total++;
    if (obs() !== exp) begin
      bad++;
      $display("FAIL add: got %h want %h", obs(), exp);
    end
    drive(2'd0, 16'h0005, 16'h000A, 1'b0, 1'b0);
    tick();
    exp = {16'h000F, 1'b0, 1'b0, 1'b0, 1'b0};
    total++;
    if (obs() !== exp) begin
      bad++;
      $display("FAIL add_valid_drop: got %h want %h", obs(), exp);
    end
  endtask

  task automatic test_sub_flags_only();
    logic [19:0] exp;
    drive(2'd1, 16'h0007, 16'h0007, 1'b0, 1'b1);
    tick();
    exp = {16'h000F, 1'b1, 1'b0, 1'b0, 1'b0};
    total++;
    if (obs() !== exp) begin
      bad++;
      $display("FAIL sub_loads_only: got %h want %h", obs(), exp);
    end
  endtask

  task automatic test_wrap();
    logic [19:0] exp;
    drive(2'd0, 16'h7FFF, 16'h0001, 1'b1, 1'b1);
    tick();
    exp = {16'h8000, 1'b0, 1'b1, OVF, 1'b1};
    total++;
    if (obs() !== exp) begin
      bad++;
      $display("FAIL wrap_pos: got %h want %h", obs(), exp);
    end
    drive(2'd0, 16'hFFFF, 16'h0001, 1'b1, 1'b1);
    tick();
    exp = {16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
    total++;
    if (obs() !== exp) begin
      bad++;
      $display("FAIL wrap_zero: got %h want %h", obs(), exp);
    end
    drive(2'd1, 16'h8000, 16'h0001, 1'b0, 1'b1);
    tick();
    exp = {16'h0000, 1'b0, 1'b0, OVF, 1'b0};
    total++;
    if (obs() !== exp) begin
      bad++;
      $display("FAIL sub_ovf: got %h want %h", obs(), exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] exp;
    drive(2'd2, 16'hF0F0, 16'h3C3C, 1'b1, 1'b0);
    tick();
    exp = {16'h3030, 1'b0, 1'b0, OVF, 1'b1};
    total++;
    if (obs() !== exp) begin
      bad++;
      $display("FAIL b2b_and: got %h want %h", obs(), exp);
    end
    drive(2'd3, 16'hF0F0, 16'h3C3C, 1'b1, 1'b0);
    tick();
    exp = {16'hC3C3, 1'b0, 1'b0, OVF, 1'b1};
    total++;
    if (obs() !== exp) begin
      bad++;
      $display("FAIL b2b_not: got %h want %h", obs(), exp);
    end
    drive(2'd3, 16'h0000, 16'hFFFF, 1'b0, 1'b1);
    tick();
    exp = {16'hC3C3, 1'b1, 1'b0, 1'b0, 1'b0};
    total++;
    if (obs() !== exp) begin
      bad++;
      $display("FAIL not_flags: got %h want %h", obs(), exp);
    end
  endtask

  task automatic test_reset_mid();
    logic [19:0] exp;
    rst_n = 1'b0;
    drive(2'd0, 16'h1111, 16'h2222, 1'b1, 1'b1);
    tick();
    exp = {16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
    total++;
    if (obs() !== exp) begin
      bad++;
      $display("FAIL reset_mid: got %h want %h", obs(), exp);
    end
    rst_n = 1'b1;
    bus.loadc = 1'b0;
    bus.loads = 1'b0;
    tick();
    total++;
    if (obs() !== exp) begin
      bad++;
      $display("FAIL reset_mid_after: got %h want %h", obs(), exp);
    end
  endtask

  task automatic test_hold();
    logic [19:0] snap;
    drive(2'd0, 16'h1357, 16'h2468, 1'b1, 1'b1);
    tick();
    snap = obs();
    snap[0] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(2'($urandom), 16'($urandom), 16'($urandom), 1'b0, 1'b0);
      tick();
      total++;
      if (obs() !== snap) begin
        bad++;
        $display("FAIL hold[%0d]: got %h want %h", i, obs(), snap);
      end
    end
  endtask

  task automatic test_random();
    logic [19:0] exp;
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 24) != 0);
      drive(2'($urandom), 16'($urandom), 16'($urandom),
            1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) bus.ain = 16'h7FFF ^ 16'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) bus.bin = 16'h8000 ^ 16'($urandom_range(0, 3));
      tick();
      exp = {ec, ez, en, ev, ecv};
      total++;
      if (obs() !== exp) begin
        bad++;
        $display("FAIL random[%0d]: got %h want %h", i, obs(), exp);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    ec = 16'h0; ez = 0; en = 0; ev = 0; ecv = 0;
    drive(2'd0, 16'h0, 16'h0, 1'b0, 1'b0);
    test_reset();
    test_add();
    test_sub_flags_only();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
